// File: rtl/vec_norm_join.sv
// ----------------------------------------------------------------------------
// vec_norm_join
//
// Pairing stage around the vector-norm unit. Each accepted 3-vector is forked
// combinationally to the norm unit and a copy is parked in a show-ahead FIFO.
// When the in-order norm unit returns a norm, it is joined with the oldest
// parked vector and presented as one {norm, z, y, x} beat through a single
// output register.
//
// Ports
//   aclk, areset            clock (rising edge), async active-high reset
//   s_axis_vec_*            incoming vector [0]=x [1]=y [2]=z
//   m_axis_norm_*           vector forked to the norm unit
//   s_axis_norm_*           norm returned by the norm unit
//   m_axis_result_*         joined beat, [2:0]=vector, [3]=norm
//   occupancy               vectors parked and still waiting for their norm
//   err_orphan              sticky flag: a norm arrived with nothing parked
// ----------------------------------------------------------------------------
module vec_norm_join #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 64
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [2:0][SIZE-1:0]       s_axis_vec_tdata,
    input  logic                       s_axis_vec_tvalid,
    output logic                       s_axis_vec_tready,
    output logic [2:0][SIZE-1:0]       m_axis_norm_tdata,
    output logic                       m_axis_norm_tvalid,
    input  logic                       m_axis_norm_tready,
    input  logic [SIZE-1:0]            s_axis_norm_tdata,
    input  logic                       s_axis_norm_tvalid,
    output logic                       s_axis_norm_tready,
    output logic [3:0][SIZE-1:0]       m_axis_result_tdata,
    output logic                       m_axis_result_tvalid,
    input  logic                       m_axis_result_tready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_orphan
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vec_norm_join: DEPTH must be a power of 2 and at least 2");
    end

    logic [2:0][SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [OW-1:0]        r_occ;
    logic                 r_err;
    logic                 r_res_vld;
    logic [3:0][SIZE-1:0] r_res_data;

    logic                 w_space;
    logic                 w_push;
    logic                 w_norm_hs;
    logic                 w_pop;
    logic                 w_orphan;
    logic [2:0][SIZE-1:0] w_head;

    // Fork: space is taken from the registered count, so a pop in the same
    // cycle never lets a push through at full.
    assign w_space            = (r_occ < OW'(DEPTH));
    assign m_axis_norm_tdata  = s_axis_vec_tdata;
    assign m_axis_norm_tvalid = s_axis_vec_tvalid & w_space;
    assign s_axis_vec_tready  = m_axis_norm_tready & w_space;
    assign w_push             = s_axis_vec_tvalid & m_axis_norm_tready & w_space;

    // Join: the output register accepts a new norm whenever it is empty or
    // draining this cycle.
    assign s_axis_norm_tready = ~r_res_vld | m_axis_result_tready;
    assign w_norm_hs          = s_axis_norm_tvalid & s_axis_norm_tready;
    assign w_pop              = w_norm_hs & (r_occ != '0);
    assign w_orphan           = w_norm_hs & (r_occ == '0);
    assign w_head             = r_mem[r_rd_ptr];

    // FIFO storage is deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_vec_tdata;
        end
    end

    // FIFO control: pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    // Output register: a load wins over a drain so back-to-back beats keep
    // tvalid high; an orphan norm leaves the register untouched.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
        end else if (w_pop) begin
            r_res_vld  <= 1'b1;
            r_res_data <= {s_axis_norm_tdata, w_head};
        end else if (m_axis_result_tready) begin
            r_res_vld  <= 1'b0;
        end
    end

    assign m_axis_result_tvalid = r_res_vld;
    assign m_axis_result_tdata  = r_res_data;
    assign occupancy            = r_occ;
    assign err_orphan           = r_err;

endmodule

// File: tb/tb_vec_norm_join.sv
module tb_vec_norm_join;
    localparam int SIZE  = 32;
    localparam int DEPTH = 64;
    localparam int LAT   = 59;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam logic [31:0] F1 = 32'h3F80_0000; // 1.0
    localparam logic [31:0] F2 = 32'h4000_0000; // 2.0
    localparam logic [31:0] F3 = 32'h4040_0000; // 3.0

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic [2:0][SIZE-1:0] s_axis_vec_tdata = '0;
    logic                 s_axis_vec_tvalid = 1'b0;
    logic                 s_axis_vec_tready;
    logic [2:0][SIZE-1:0] m_axis_norm_tdata;
    logic                 m_axis_norm_tvalid;
    logic                 m_axis_norm_tready = 1'b1;
    logic [SIZE-1:0]      s_axis_norm_tdata;
    logic                 s_axis_norm_tvalid;
    logic                 s_axis_norm_tready;
    logic [3:0][SIZE-1:0] m_axis_result_tdata;
    logic                 m_axis_result_tvalid;
    logic                 m_axis_result_tready = 1'b1;
    logic [OW-1:0]        occupancy;
    logic                 err_orphan;

    // norm source mux: behavioural norm unit or directly injected beat
    logic        inj = 1'b0;
    logic        inj_tvalid = 1'b0;
    logic [31:0] inj_tdata = '0;
    logic        model_vld = 1'b0;
    logic [31:0] model_data = '0;

    assign s_axis_norm_tvalid = inj ? inj_tvalid : model_vld;
    assign s_axis_norm_tdata  = inj ? inj_tdata  : model_data;

    vec_norm_join #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_vec_tdata     (s_axis_vec_tdata),
        .s_axis_vec_tvalid    (s_axis_vec_tvalid),
        .s_axis_vec_tready    (s_axis_vec_tready),
        .m_axis_norm_tdata    (m_axis_norm_tdata),
        .m_axis_norm_tvalid   (m_axis_norm_tvalid),
        .m_axis_norm_tready   (m_axis_norm_tready),
        .s_axis_norm_tdata    (s_axis_norm_tdata),
        .s_axis_norm_tvalid   (s_axis_norm_tvalid),
        .s_axis_norm_tready   (s_axis_norm_tready),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tready (m_axis_result_tready),
        .occupancy            (occupancy),
        .err_orphan           (err_orphan)
    );

    always #5 aclk = ~aclk;

    // stand-in norm: exact 3.0 for (1,2,2), otherwise sum of the words
    function automatic logic [31:0] fnorm(input logic [95:0] v);
        if (v == {F2, F2, F1}) return F3;
        return v[31:0] + v[63:32] + v[95:64];
    endfunction

    function automatic logic [95:0] vecn(input int i);
        return {32'h0001_0000 + i, 32'h0000_0100 + i, 32'h0000_0001 + i};
    endfunction

    function automatic logic [127:0] expr(input logic [95:0] v);
        return {fnorm(v), v};
    endfunction

    // in-order, elastic norm unit with LAT cycles of latency
    typedef struct packed { logic [95:0] v; int due; } ent_t;
    ent_t nq[$];
    int   cyc = 0;

    always @(posedge aclk) begin
        ent_t e;
        cyc = cyc + 1;
        if (areset) begin
            nq.delete();
            model_vld <= 1'b0;
        end else begin
            if (model_vld && !inj && s_axis_norm_tready && nq.size() > 0)
                void'(nq.pop_front());
            if (m_axis_norm_tvalid && m_axis_norm_tready) begin
                e.v   = m_axis_norm_tdata;
                e.due = cyc + LAT;
                nq.push_back(e);
            end
            if (nq.size() > 0 && nq[0].due <= cyc) begin
                model_vld  <= 1'b1;
                model_data <= fnorm(nq[0].v);
            end else begin
                model_vld  <= 1'b0;
            end
        end
    end

    // result monitor: records each beat that completes at the next edge
    logic [127:0] got_q[$];
    always @(negedge aclk) begin
        if (!areset && m_axis_result_tvalid && m_axis_result_tready)
            got_q.push_back(m_axis_result_tdata);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_one(input logic [95:0] v);
        s_axis_vec_tdata  = v;
        s_axis_vec_tvalid = 1'b1;
        tick();
        s_axis_vec_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge aclk);
            k++;
        end
        check({tag, "_beats"}, got_q.size(), n);
    endtask

    initial begin
        int k;
        int drops;
        int peak;
        int acc;
        logic [127:0] held;

        // reset state
        #2;
        check("rst_tvalid", m_axis_result_tvalid, 0);
        check("rst_tdata", m_axis_result_tdata, 0);
        check("rst_occ", occupancy, 0);
        check("rst_err", err_orphan, 0);
        tick();
        tick();
        areset = 1'b0;
        s_axis_vec_tvalid  = 1'b1;
        m_axis_norm_tready = 1'b0;
        #1;
        check("post_rst_norm_tvalid", m_axis_norm_tvalid, 1);
        check("post_rst_vec_tready_lo", s_axis_vec_tready, 0);
        check("post_rst_norm_tready", s_axis_norm_tready, 1);
        s_axis_vec_tvalid  = 1'b0;
        m_axis_norm_tready = 1'b1;
        #1;
        check("post_rst_vec_tready_hi", s_axis_vec_tready, 1);
        check("post_rst_norm_tvalid_lo", m_axis_norm_tvalid, 0);
        tick();

        // single vector (1,2,2) -> 3
        got_q.delete();
        push_one({F2, F2, F1});
        check("single_occ_wait", occupancy, 1);
        k = 0;
        while (!(s_axis_norm_tvalid && s_axis_norm_tready) && k < 200) begin
            @(negedge aclk);
            k++;
        end
        check("single_norm_seen", k < 200, 1);
        check("single_occ_before", occupancy, 1);
        check("single_tvalid_before", m_axis_result_tvalid, 0);
        @(negedge aclk);
        check("single_tvalid", m_axis_result_tvalid, 1);
        check("single_tdata", m_axis_result_tdata, {F3, F2, F2, F1});
        check("single_occ_after", occupancy, 0);
        tick();
        tick();

        // streaming 200 back-to-back vectors
        got_q.delete();
        drops = 0;
        peak  = 0;
        for (int i = 0; i < 200; i++) begin
            s_axis_vec_tdata  = vecn(i);
            s_axis_vec_tvalid = 1'b1;
            @(negedge aclk);
            if (!s_axis_vec_tready) drops++;
            if (int'(occupancy) > peak) peak = int'(occupancy);
            tick();
        end
        s_axis_vec_tvalid = 1'b0;
        wait_beats(200, 400, "stream");
        check("stream_drops", drops, 0);
        check("stream_peak_59_60", (peak == 59 || peak == 60), 1);
        for (int i = 0; i < 200; i++)
            check($sformatf("stream_%0d", i), (i < got_q.size()) ? got_q[i] : 128'bx, expr(vecn(i)));
        tick();

        // full: downstream stalled for 300 cycles
        got_q.delete();
        m_axis_result_tready = 1'b0;
        acc = 0;
        for (int c = 0; c < 300; c++) begin
            s_axis_vec_tdata  = vecn(1000 + acc);
            s_axis_vec_tvalid = 1'b1;
            @(negedge aclk);
            if (s_axis_vec_tready) acc++;
            tick();
        end
        check("full_occ", occupancy, 64);
        check("full_vec_tready", s_axis_vec_tready, 0);
        check("full_norm_tvalid", m_axis_norm_tvalid, 0);
        check("full_accepted", acc, 65);
        check("full_held", m_axis_result_tdata, expr(vecn(1000)));
        s_axis_vec_tvalid    = 1'b0;
        m_axis_result_tready = 1'b1;
        wait_beats(acc, 400, "full");
        tick();
        tick();
        check("full_no_dup", got_q.size(), acc);
        for (int i = 0; i < acc; i++)
            check($sformatf("full_%0d", i), (i < got_q.size()) ? got_q[i] : 128'bx, expr(vecn(1000 + i)));
        check("full_occ_drained", occupancy, 0);

        // output stall with a second norm waiting
        got_q.delete();
        m_axis_result_tready = 1'b0;
        s_axis_vec_tvalid    = 1'b1;
        s_axis_vec_tdata     = vecn(2000);
        tick();
        s_axis_vec_tdata     = vecn(2001);
        tick();
        s_axis_vec_tvalid    = 1'b0;
        k = 0;
        while (!m_axis_result_tvalid && k < 200) begin
            @(negedge aclk);
            k++;
        end
        held = m_axis_result_tdata;
        check("stall_first", held, expr(vecn(2000)));
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            check("stall_stable", m_axis_result_tdata, held);
            check("stall_norm_tready", s_axis_norm_tready, 0);
        end
        check("stall_norm_waiting", s_axis_norm_tvalid, 1);
        tick();
        m_axis_result_tready = 1'b1;
        @(negedge aclk);
        check("stall_release_hs", s_axis_norm_tvalid && s_axis_norm_tready, 1);
        @(negedge aclk);
        check("stall_second_vld", m_axis_result_tvalid, 1);
        check("stall_second", m_axis_result_tdata, expr(vecn(2001)));
        wait_beats(2, 20, "stall");
        tick();
        tick();

        // orphan norm with nothing parked
        got_q.delete();
        inj        = 1'b1;
        inj_tvalid = 1'b1;
        inj_tdata  = 32'hDEAD_BEEF;
        tick();
        inj_tvalid = 1'b0;
        check("orphan_err", err_orphan, 1);
        check("orphan_no_vld", m_axis_result_tvalid, 0);
        check("orphan_occ", occupancy, 0);
        inj = 1'b0;
        repeat (3) tick();
        check("orphan_err_sticky", err_orphan, 1);
        check("orphan_no_beat", got_q.size(), 0);
        push_one(vecn(3000));
        wait_beats(1, 100, "orphan_after");
        check("orphan_after_pair", (got_q.size() > 0) ? got_q[0] : 128'bx, expr(vecn(3000)));
        check("orphan_err_kept", err_orphan, 1);
        tick();
        tick();

        // reset with 10 vectors parked
        got_q.delete();
        s_axis_vec_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_axis_vec_tdata = vecn(4000 + i);
            tick();
        end
        s_axis_vec_tvalid = 1'b0;
        check("rst_mid_occ_before", occupancy, 10);
        areset = 1'b1;
        #1;
        check("rst_mid_occ", occupancy, 0);
        check("rst_mid_tvalid", m_axis_result_tvalid, 0);
        check("rst_mid_err", err_orphan, 0);
        tick();
        tick();
        areset = 1'b0;
        tick();
        push_one(vecn(5000));
        wait_beats(1, 100, "rst_mid");
        check("rst_mid_pair", (got_q.size() > 0) ? got_q[0] : 128'bx, expr(vecn(5000)));
        repeat (70) tick();
        check("rst_mid_no_stale", got_q.size(), 1);
        check("rst_mid_occ_end", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
